// File: rtl/wired_net_resolver.sv
// wired_net_resolver
// Resolves NDRV drivers of a WIDTH-bit net per accepted beat using tri/wire,
// wired-OR or wired-AND semantics. Each result is held in a one-deep output
// register behind a valid/ready handshake. The output carries per-bit undriven
// (z) and conflict (x) masks. The block also keeps a saturating count of
// conflict beats and a sticky conflict flag.
module wired_net_resolver #(
    parameter int NDRV  = 4,
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NDRV-1:0]       drv_en,
    input  logic [NDRV*WIDTH-1:0] drv_data,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [WIDTH-1:0]      out_z,
    output logic [WIDTH-1:0]      out_x,
    output logic [CNT_W-1:0]      conflict_cnt,
    output logic                  conflict_sticky,
    input  logic                  clr
);

    typedef enum logic [1:0] {
        MODE_TRI  = 2'd0,
        MODE_WOR  = 2'd1,
        MODE_WAND = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Gather bit b of every driver into one NDRV-wide column.
    function automatic logic [NDRV-1:0] column(input logic [NDRV*WIDTH-1:0] dd,
                                               input int                    b);
        logic [NDRV-1:0] c;
        c = '0;
        for (int i = 0; i < NDRV; i++) begin
            c[i] = dd[i*WIDTH + b];
        end
        return c;
    endfunction

    // Resolve one net bit. Returns {z, x, data}. Disabled drivers are masked
    // out first, so only enabled drivers can pull a bit high or low.
    function automatic logic [2:0] resolve_bit(input logic [NDRV-1:0] en,
                                               input logic [NDRV-1:0] col,
                                               input logic [1:0]      m);
        logic any1;
        logic any0;
        logic d;
        logic x;
        logic z;
        any1 = |(en & col);
        any0 = |(en & ~col);
        z    = ~(|en);
        x    = 1'b0;
        d    = 1'b0;
        if (!z) begin
            case (mode_e'(m))
                MODE_WOR:  d = any1;
                MODE_WAND: d = ~any0;
                MODE_TRI, MODE_RSVD: begin
                    x = any1 & any0;
                    d = any1 & ~any0;
                end
                default: begin
                    x = any1 & any0;
                    d = any1 & ~any0;
                end
            endcase
        end
        return {z, x, d};
    endfunction

    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] res_z;
    logic [WIDTH-1:0] res_x;
    logic             accept;

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [WIDTH-1:0] z_q,      z_d;
    logic [WIDTH-1:0] x_q,      x_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             sticky_q, sticky_d;

    // The output slot frees up when it is empty or being popped this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Combinational resolution of the beat currently on the inputs.
    always_comb begin
        res_data = '0;
        res_z    = '0;
        res_x    = '0;
        for (int b = 0; b < WIDTH; b++) begin
            {res_z[b], res_x[b], res_data[b]} =
                resolve_bit(drv_en, column(drv_data, b), mode);
        end
    end

    // Next state for the output slot and the conflict accounting.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        z_d      = z_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (accept) begin
            valid_d = 1'b1;
            data_d  = res_data;
            z_d     = res_z;
            x_d     = res_x;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        // A clear wins over a coinciding conflict beat.
        if (clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (accept && (|res_x)) begin
            cnt_d    = sat_inc(cnt_q);
            sticky_d = 1'b1;
        end
    end

    // State registers; reset discards any result still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            z_q      <= '0;
            x_q      <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            z_q      <= z_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_data        = data_q;
    assign out_z           = z_q;
    assign out_x           = x_q;
    assign conflict_cnt    = cnt_q;
    assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_wired_net_resolver.sv
// Bench for wired_net_resolver: main instance (CNT_W=8) plus a CNT_W=2
// instance for counter saturation.
module tb_wired_net_resolver;

    localparam int NDRV  = 4;
    localparam int WIDTH = 3;
    localparam int CNT_W = 8;
    localparam int SCW   = 2;
    localparam logic [NDRV*WIDTH-1:0] CONFLICT = {3'b000, 3'b000, 3'b100, 3'b101};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  in_valid, in_ready, out_valid, out_ready, clr, conflict_sticky;
    logic [NDRV-1:0]       drv_en;
    logic [NDRV*WIDTH-1:0] drv_data;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      out_data, out_z, out_x;
    logic [CNT_W-1:0]      conflict_cnt;

    logic                  s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr, s_sticky;
    logic [NDRV-1:0]       s_drv_en;
    logic [NDRV*WIDTH-1:0] s_drv_data;
    logic [1:0]            s_mode;
    logic [WIDTH-1:0]      s_out_data, s_out_z, s_out_x;
    logic [SCW-1:0]        s_cnt;

    wired_net_resolver #(.NDRV(NDRV), .WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .drv_en(drv_en), .drv_data(drv_data), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_z(out_z), .out_x(out_x), .conflict_cnt(conflict_cnt),
        .conflict_sticky(conflict_sticky), .clr(clr)
    );

    wired_net_resolver #(.NDRV(NDRV), .WIDTH(WIDTH), .CNT_W(SCW)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .drv_en(s_drv_en), .drv_data(s_drv_data), .mode(s_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_z(s_out_z), .out_x(s_out_x), .conflict_cnt(s_cnt),
        .conflict_sticky(s_sticky), .clr(s_clr)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] x;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: counts enabled ones and zeros per bit.
    function automatic exp_t model(input logic [NDRV-1:0] en,
                                   input logic [NDRV*WIDTH-1:0] dd,
                                   input logic [1:0] m);
        exp_t e;
        int ones;
        int zeros;
        e = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ones = 0;
            zeros = 0;
            for (int i = 0; i < NDRV; i++) begin
                if (en[i]) begin
                    if (dd[i*WIDTH + b]) ones++;
                    else zeros++;
                end
            end
            if (ones + zeros == 0) e.z[b] = 1'b1;
            else if (m == 2'd1) e.d[b] = (ones > 0);
            else if (m == 2'd2) e.d[b] = (zeros == 0);
            else if (ones > 0 && zeros > 0) e.x[b] = 1'b1;
            else e.d[b] = (ones > 0);
        end
        return e;
    endfunction

    // Present one beat and push its expected result when it is accepted.
    task automatic drive_beat(input logic [NDRV-1:0] en,
                              input logic [NDRV*WIDTH-1:0] dd,
                              input logic [1:0] m);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        drv_en   = en;
        drv_data = dd;
        mode     = m;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        sbq.push_back(model(en, dd, m));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_z, out_x, conflict_cnt, conflict_sticky, s_out_valid, s_cnt, s_sticky} !== '0) begin
            errors++;
            $display("FAIL reset_state v=%b d=%b z=%b x=%b cnt=%0d st=%b s_cnt=%0d required all 0",
                     out_valid, out_data, out_z, out_x, conflict_cnt, conflict_sticky, s_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_beat(4'b0011, CONFLICT, 2'd0);
            e = sbq.pop_front();
            checks++;
            if ({out_valid, out_data, out_z, out_x} !== {1'b1, e.d, e.z, e.x}) begin
                errors++;
                $display("FAIL preload_beat%0d v=%b d=%b z=%b x=%b required d=%b z=%b x=%b",
                         k, out_valid, out_data, out_z, out_x, e.d, e.z, e.x);
            end
        end
        checks++;
        if (conflict_cnt !== 8'd5 || conflict_sticky !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL preload_state cnt=%0d st=%b v=%b required 5 1 1", conflict_cnt, conflict_sticky, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_z, out_x, conflict_cnt, conflict_sticky} !== '0) begin
            errors++;
            $display("FAIL async_reset v=%b d=%b z=%b x=%b cnt=%0d st=%b required all 0",
                     out_valid, out_data, out_z, out_x, conflict_cnt, conflict_sticky);
        end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tri();
        exp_t e;
        out_ready = 1'b1;
        drive_beat(4'b0011, CONFLICT, 2'd0);
        e = sbq.pop_front();
        checks++;
        if ({out_valid, out_data, out_z, out_x} !== {1'b1, e.d, e.z, e.x}) begin
            errors++;
            $display("FAIL tri_sb d=%b z=%b x=%b required d=%b z=%b x=%b", out_data, out_z, out_x, e.d, e.z, e.x);
        end
        checks++;
        if ({out_data, out_x, out_z} !== 9'b100_001_000 || conflict_cnt !== 8'd1 || conflict_sticky !== 1'b1) begin
            errors++;
            $display("FAIL tri_const d=%b x=%b z=%b cnt=%0d st=%b required 100 001 000 1 1",
                     out_data, out_x, out_z, conflict_cnt, conflict_sticky);
        end
    endtask

    task automatic test_wor_wand();
        exp_t e;
        logic [WIDTH-1:0] want_d[3];
        logic [CNT_W-1:0] want_c[3];
        want_d = '{3'b101, 3'b100, 3'b100};
        want_c = '{8'd1, 8'd1, 8'd2};
        for (int k = 0; k < 3; k++) begin
            drive_beat(4'b0011, CONFLICT, 2'(k + 1));
            e = sbq.pop_front();
            checks++;
            if ({out_valid, out_data, out_z, out_x} !== {1'b1, e.d, e.z, e.x}) begin
                errors++;
                $display("FAIL mode%0d_sb d=%b z=%b x=%b required d=%b z=%b x=%b",
                         k + 1, out_data, out_z, out_x, e.d, e.z, e.x);
            end
            checks++;
            if (out_data !== want_d[k] || conflict_cnt !== want_c[k]) begin
                errors++;
                $display("FAIL mode%0d_const d=%b cnt=%0d required d=%b cnt=%0d",
                         k + 1, out_data, conflict_cnt, want_d[k], want_c[k]);
            end
        end
    endtask

    task automatic test_all_disabled();
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            drive_beat(4'b0000, 12'($urandom), 2'(m));
            e = sbq.pop_front();
            checks++;
            if ({out_valid, out_data, out_z, out_x} !== {1'b1, e.d, e.z, e.x} ||
                {out_data, out_z, out_x} !== 9'b000_111_000) begin
                errors++;
                $display("FAIL disabled_mode%0d d=%b z=%b x=%b required d=000 z=111 x=000", m, out_data, out_z, out_x);
            end
        end
        checks++;
        if (conflict_cnt !== 8'd2) begin
            errors++;
            $display("FAIL disabled_cnt cnt=%0d required 2", conflict_cnt);
        end
    endtask

    task automatic test_clr();
        logic [3*WIDTH:0] snap;
        @(negedge clk);
        out_ready = 1'b0;
        snap = {out_valid, out_data, out_z, out_x};
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checks++;
        if (conflict_cnt !== 8'd0 || conflict_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_cnt cnt=%0d st=%b required 0 0", conflict_cnt, conflict_sticky);
        end
        checks++;
        if ({out_valid, out_data, out_z, out_x} !== snap) begin
            errors++;
            $display("FAIL clr_outputs got %b required %b", {out_valid, out_data, out_z, out_x}, snap);
        end
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        exp_t ea;
        exp_t eb;
        logic [NDRV*WIDTH-1:0] bdata;
        bdata = {3'b111, 3'b110, 3'b011, 3'b111};
        out_ready = 1'b1;
        drive_beat(4'b0011, CONFLICT, 2'd1);
        ea = sbq.pop_front();
        checks++;
        if ({out_valid, out_data, out_z, out_x} !== {1'b1, ea.d, ea.z, ea.x}) begin
            errors++;
            $display("FAIL bp_first d=%b required %b", out_data, ea.d);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drv_en    = 4'b1111;
        drv_data  = bdata;
        mode      = 2'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_cycle%0d in_ready=%b required 0", k, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, out_data, out_z, out_x} !== {1'b1, ea.d, ea.z, ea.x}) begin
                errors++;
                $display("FAIL bp_hold_cycle%0d v=%b d=%b required v=1 d=%b", k, out_valid, out_data, ea.d);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        sbq.push_back(model(4'b1111, bdata, 2'd2));
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        eb = sbq.pop_front();
        checks++;
        if ({out_valid, out_data, out_z, out_x} !== {1'b1, eb.d, eb.z, eb.x} || out_data !== 3'b010) begin
            errors++;
            $display("FAIL bp_replace v=%b d=%b z=%b x=%b required d=%b (010)", out_valid, out_data, out_z, out_x, eb.d);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_pop_only out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int exp_cnt;
        exp_cnt = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive_beat(4'($urandom_range(0, 15)), 12'($urandom), 2'($urandom_range(0, 3)));
            e = sbq.pop_front();
            if (e.x != '0) exp_cnt++;
            checks++;
            if ({out_valid, out_data, out_z, out_x} !== {1'b1, e.d, e.z, e.x}) begin
                errors++;
                $display("FAIL b2b_beat%0d d=%b z=%b x=%b required d=%b z=%b x=%b",
                         k, out_data, out_z, out_x, e.d, e.z, e.x);
            end
        end
        checks++;
        if (conflict_cnt !== CNT_W'(exp_cnt) || conflict_sticky !== (exp_cnt > 0)) begin
            errors++;
            $display("FAIL b2b_cnt cnt=%0d st=%b required %0d", conflict_cnt, conflict_sticky, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [SCW-1:0] want[5];
        want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        s_drv_en   = 4'b0011;
        s_drv_data = CONFLICT;
        s_mode     = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            checks++;
            if (s_cnt !== want[k] || s_sticky !== 1'b1) begin
                errors++;
                $display("FAIL sat_beat%0d cnt=%0d st=%b required %0d 1", k, s_cnt, s_sticky, want[k]);
            end
        end
        checks++;
        if ({s_in_ready, s_out_valid, s_out_data, s_out_z, s_out_x} !== 11'b11_100_000_001) begin
            errors++;
            $display("FAIL sat_result rdy=%b v=%b d=%b z=%b x=%b required 1 1 100 000 001",
                     s_in_ready, s_out_valid, s_out_data, s_out_z, s_out_x);
        end
        @(negedge clk);
        s_in_valid = 1'b1;
        s_clr = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_clr = 1'b0;
        checks++;
        if (s_cnt !== 2'd0 || s_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr_wins cnt=%0d st=%b required 0 0", s_cnt, s_sticky);
        end
        @(negedge clk);
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        checks++;
        if (s_cnt !== 2'd1 || s_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sat_after_clr cnt=%0d st=%b required 1 1", s_cnt, s_sticky);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        drv_en = '0; drv_data = '0; mode = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_clr = 1'b0;
        s_drv_en = '0; s_drv_data = '0; s_mode = '0;
        test_reset();
        test_tri();
        test_wor_wand();
        test_all_disabled();
        test_clr();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/wired_net_resolver.md
Name: wired_net_resolver

Overview:
- Parametrised, clocked successor to the gate-level multi-driven-net blocks.
- Resolves NDRV independent drivers of a WIDTH-bit net each accepted beat, using wire/tri, wired-OR or wired-AND semantics.
- Reports per-bit undriven (z) and conflict (x) masks, and keeps a saturating conflict counter plus a sticky flag.
- Sits between driver-model generators and the net checker, behind a valid/ready handshake.

Parameters:
- NDRV, 4, number of drivers (1..16).
- WIDTH, 3, net width in bits (1..64).
- CNT_W, 8, conflict counter width (2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat present on the drv_* and mode inputs.
- in_ready  output  1  block can accept a beat.
- drv_en  input  NDRV  per-driver enable; 0 means the driver outputs z.
- drv_data  input  NDRV*WIDTH  driver values; driver i occupies bits [i*WIDTH +: WIDTH].
- mode  input  2  0=tri/wire, 1=wor, 2=wand, 3=reserved, treated as 0.
- out_valid  output  1  resolved result held in the output register.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  resolved value; 0 wherever out_z or out_x is set.
- out_z  output  WIDTH  bit had no enabled driver.
- out_x  output  WIDTH  bit had a conflict (tri mode only).
- conflict_cnt  output  CNT_W  count of beats with any x bit; saturates.
- conflict_sticky  output  1  set by any conflict beat.
- clr  input  1  synchronous clear of conflict_cnt and conflict_sticky.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_z=0, out_x=0, conflict_cnt=0, conflict_sticky=0.
- Reset mid-operation: the in-flight result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Latency is 1: an accepted beat appears in the out_* registers with out_valid=1 the next cycle.
  - out_valid stays high and the outputs stay stable until out_ready.
  - Pop and accept in the same cycle replace the result with no bubble.
  - Pop without accept clears out_valid.
  - mode is sampled only on accept.
- Resolution, per bit b, over the enabled drivers:
  - No enabled driver, any mode: z=1, x=0, data=0.
  - tri: all enabled drivers agree gives data=value; disagreement gives x=1, data=0.
  - wor: data = OR of enabled drivers; x never set.
  - wand: data = AND of enabled drivers; x never set.
- Conflict accounting, applied on accept when the resolved x mask is nonzero:
  - conflict_cnt increments, holding at 2^CNT_W-1.
  - conflict_sticky is set.
- clr:
  - Takes effect at the next edge regardless of handshake.
  - When clr and an increment land in the same cycle, clr wins: cnt=0, sticky=0.
  - Does not affect out_*.
- Boundaries:
  - NDRV=1 can never produce x.
  - An all-drivers-disabled beat is legal and yields out_z all-ones.
  - A saturated counter holds and the sticky flag stays 1.
  - in_valid with in_ready=0 is held by the producer; the block does not latch it.

Test Plan:
- Reset with out_valid=1 and conflict_cnt=5, assert rst_n=0 asynchronously -> all outputs 0 immediately, before the next edge.
- NDRV=4, WIDTH=3, mode=0, en=4'b0011, drv0=3'b101, drv1=3'b100 -> next cycle out_data=3'b100, out_x=3'b001, out_z=0, conflict_cnt=1, sticky=1.
- Same drivers with mode=1 -> out_data=3'b101, out_x=0, cnt unchanged; mode=2 -> out_data=3'b100.
- en=4'b0000 in every mode -> out_z=3'b111, out_data=0, out_x=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, no accept; out_ready=1 then gives pop and accept in the same cycle, and the new result appears next cycle.
- CNT_W=2: 5 conflicting beats -> cnt reads 1,2,3,3,3. clr coincident with a conflict beat -> cnt=0, sticky=0; the following conflict beat -> cnt=1.
